// File: rtl/lane_bitorder.sv
// rtl/lane_bitorder.sv - ping-pong word buffer that re-emits incoming lanes in forward or reversed lane order
// Buffer A fills first out of reset; each completed word drains for exactly N cycles while the other buffer fills.
module lane_bitorder #(
  parameter int LANE_W = 2,
  parameter int WORD_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axiiv,
  input  logic [LANE_W-1:0] axiid,
  input  logic              reverse,
  output logic              axiov,
  output logic [LANE_W-1:0] axiod,
  output logic              frag_drop,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int N  = WORD_W / LANE_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    EMPTY_A = 2'd0,
    EMPTY_B = 2'd1,
    SEND_A  = 2'd2,
    SEND_B  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     fill_q, fill_d;
  logic [CW-1:0]     drain_q, drain_d;
  logic [WORD_W-1:0] buf_a_q, buf_a_d;
  logic [WORD_W-1:0] buf_b_q, buf_b_d;
  logic              rev_q, rev_d;
  logic              frag_q, frag_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              fill_to_a;
  logic              sending;
  logic              word_done;
  logic              drain_done;
  logic [CW-1:0]     lane_idx;
  logic [WORD_W-1:0] drain_word;

  // The fill target is always the buffer that is not draining (or was drained last).
  always_comb begin
    fill_to_a  = (state_q == EMPTY_B) || (state_q == SEND_B);
    sending    = (state_q == SEND_A) || (state_q == SEND_B);
    word_done  = axiiv && (fill_q == LAST);
    drain_done = sending && (drain_q == LAST);
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    drain_d = '0;
    buf_a_d = buf_a_q;
    buf_b_d = buf_b_q;
    rev_d   = rev_q;
    frag_d  = 1'b0;
    cnt_d   = cnt_q;

    if (axiiv) begin
      if (fill_to_a) begin
        buf_a_d[fill_q*LANE_W +: LANE_W] = axiid;
      end else begin
        buf_b_d[fill_q*LANE_W +: LANE_W] = axiid;
      end
      fill_d = word_done ? '0 : fill_q + 1'b1;
      if (word_done) begin
        rev_d = reverse;
      end
    end else if (fill_q != '0) begin
      fill_d = '0;
      frag_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (sending && !drain_done) begin
      drain_d = drain_q + 1'b1;
    end

    // A word can only complete during a send on its last drain cycle, so hand-off is gapless.
    case (state_q)
      EMPTY_B: if (word_done)  state_d = SEND_A;
      EMPTY_A: if (word_done)  state_d = SEND_B;
      SEND_A:  if (drain_done) state_d = word_done ? SEND_B : EMPTY_A;
      SEND_B:  if (drain_done) state_d = word_done ? SEND_A : EMPTY_B;
      default: state_d = EMPTY_B;
    endcase

    if (!axiiv && (state_q == SEND_A) && (state_d == EMPTY_A)) begin
      buf_a_d = '0;
    end
    if (!axiiv && (state_q == SEND_B) && (state_d == EMPTY_B)) begin
      buf_b_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY_B;
      fill_q  <= '0;
      drain_q <= '0;
      buf_a_q <= '0;
      buf_b_q <= '0;
      rev_q   <= 1'b1;
      frag_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      drain_q <= drain_d;
      buf_a_q <= buf_a_d;
      buf_b_q <= buf_b_d;
      rev_q   <= rev_d;
      frag_q  <= frag_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    lane_idx   = rev_q ? (LAST - drain_q) : drain_q;
    drain_word = (state_q == SEND_A) ? buf_a_q : buf_b_q;
    axiov      = sending;
    axiod      = sending ? drain_word[lane_idx*LANE_W +: LANE_W] : '0;
    frag_drop  = frag_q;
    drop_count = cnt_q;
  end

endmodule

// File: tb/tb_lane_bitorder.sv
// tb/tb_lane_bitorder.sv - directed self-checking bench for lane_bitorder
// dut0 uses the default geometry; dut1 uses 1-bit lanes with a 2-bit drop counter.
module tb_lane_bitorder;

  logic        clk = 1'b0;
  logic        rst, rst1;
  logic        axiiv, reverse, axiov, frag_drop;
  logic [1:0]  axiid, axiod;
  logic [15:0] drop_count;
  logic        axiiv1, reverse1, axiov1, frag_drop1;
  logic [0:0]  axiid1, axiod1;
  logic [1:0]  drop_count1;

  int n_chk  = 0;
  int n_pass = 0;

  logic       in_r [16];
  logic       in_v [16];
  logic [1:0] in_d [16];
  logic       in_rev [16];
  logic       ex_v [16];
  logic [1:0] ex_d [16];
  logic       ex_f [16];
  logic [1:0] ex_dc [16];

  always #5 clk = ~clk;

  lane_bitorder #(.LANE_W(2), .WORD_W(8), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .reverse(reverse),
    .axiov(axiov), .axiod(axiod), .frag_drop(frag_drop), .drop_count(drop_count)
  );

  lane_bitorder #(.LANE_W(1), .WORD_W(8), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst1), .axiiv(axiiv1), .axiid(axiid1), .reverse(reverse1),
    .axiov(axiov1), .axiod(axiod1), .frag_drop(frag_drop1), .drop_count(drop_count1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rst1 = 1'b1;
    axiiv = 1'b0; axiid = '0; reverse = 1'b1;
    axiiv1 = 1'b0; axiid1 = '0; reverse1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; rst1 = 1'b0;
  endtask

  task automatic clear_vec();
    for (int i = 0; i < 16; i++) begin
      in_r[i] = 1'b0; in_v[i] = 1'b0; in_d[i] = '0; in_rev[i] = 1'b1;
      ex_v[i] = 1'b0; ex_d[i] = '0; ex_f[i] = 1'b0; ex_dc[i] = '0;
    end
  endtask

  task automatic put_in(input int s, input logic rv, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic [1:0] d);
    in_v[s] = 1'b1; in_v[s+1] = 1'b1; in_v[s+2] = 1'b1; in_v[s+3] = 1'b1;
    in_d[s] = a; in_d[s+1] = b; in_d[s+2] = c; in_d[s+3] = d;
    for (int k = 0; k < 4; k++) in_rev[s+k] = rv;
  endtask

  task automatic put_exp(input int s, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] c, input logic [1:0] d);
    ex_v[s] = 1'b1; ex_v[s+1] = 1'b1; ex_v[s+2] = 1'b1; ex_v[s+3] = 1'b1;
    ex_d[s] = a; ex_d[s+1] = b; ex_d[s+2] = c; ex_d[s+3] = d;
  endtask

  // Outputs of cycle c are checked at its falling edge, then cycle c inputs are driven.
  task automatic run0(input string name, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check($sformatf("%s_axiov_c%0d", name, c), 32'(axiov), 32'(ex_v[c]));
      check($sformatf("%s_axiod_c%0d", name, c), 32'(axiod), 32'(ex_d[c]));
      check($sformatf("%s_frag_c%0d", name, c), 32'(frag_drop), 32'(ex_f[c]));
      check($sformatf("%s_dcnt_c%0d", name, c), 32'(drop_count), 32'(ex_dc[c]));
      rst = in_r[c]; axiiv = in_v[c]; axiid = in_d[c]; reverse = in_rev[c];
    end
    rst = 1'b0; axiiv = 1'b0; axiid = '0;
  endtask

  initial begin
    logic [7:0] a5;
    a5 = 8'hA5;

    do_reset();
    @(negedge clk);
    check("rst_axiov", 32'(axiov), 32'd0);
    check("rst_axiod", 32'(axiod), 32'd0);
    check("rst_frag", 32'(frag_drop), 32'd0);
    check("rst_dcnt", 32'(drop_count), 32'd0);
    check("rst1_axiov", 32'(axiov1), 32'd0);
    check("rst1_dcnt", 32'(drop_count1), 32'd0);

    // word 0x39, reversed
    clear_vec();
    put_in(0, 1'b1, 2'b01, 2'b10, 2'b11, 2'b00);
    put_exp(4, 2'b00, 2'b11, 2'b10, 2'b01);
    run0("rev1", 10);

    // word 0x39 forward; reverse only low on the completing beat
    do_reset();
    clear_vec();
    put_in(0, 1'b1, 2'b01, 2'b10, 2'b11, 2'b00);
    in_rev[3] = 1'b0;
    put_exp(4, 2'b01, 2'b10, 2'b11, 2'b00);
    run0("rev0", 10);

    // 0x39 then 0xC6 back to back
    do_reset();
    clear_vec();
    put_in(0, 1'b1, 2'b01, 2'b10, 2'b11, 2'b00);
    put_in(4, 1'b1, 2'b10, 2'b01, 2'b00, 2'b11);
    put_exp(4, 2'b00, 2'b11, 2'b10, 2'b01);
    put_exp(8, 2'b11, 2'b00, 2'b01, 2'b10);
    run0("b2b", 14);

    // partial word dropped, then a full word
    do_reset();
    clear_vec();
    put_in(0, 1'b1, 2'b01, 2'b10, 2'b11, 2'b00);
    in_v[3] = 1'b0; in_d[3] = 2'b00;
    ex_f[4] = 1'b1;
    for (int c = 4; c < 16; c++) ex_dc[c] = 2'd1;
    put_in(5, 1'b1, 2'b01, 2'b10, 2'b11, 2'b00);
    put_exp(9, 2'b00, 2'b11, 2'b10, 2'b01);
    run0("drop", 15);

    // reset on the second output beat while the next word is mid-fill
    clear_vec();
    put_in(0, 1'b1, 2'b01, 2'b10, 2'b11, 2'b00);
    in_v[4] = 1'b1; in_d[4] = 2'b10;
    in_v[5] = 1'b1; in_d[5] = 2'b01;
    in_r[5] = 1'b1;
    for (int c = 0; c < 6; c++) ex_dc[c] = 2'd1;
    ex_v[4] = 1'b1; ex_d[4] = 2'b00;
    ex_v[5] = 1'b1; ex_d[5] = 2'b11;
    put_in(7, 1'b1, 2'b10, 2'b01, 2'b00, 2'b11);
    put_exp(11, 2'b11, 2'b00, 2'b01, 2'b10);
    run0("midrst", 16);

    // 1-bit lanes: 0xA5 LSb first, reversed out at cycles 8-15
    do_reset();
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      check($sformatf("a5_axiov_c%0d", c), 32'(axiov1), 32'((c >= 8 && c <= 15) ? 1 : 0));
      check($sformatf("a5_axiod_c%0d", c), 32'(axiod1), 32'((c >= 8 && c <= 15) ? a5[15-c] : 1'b0));
      axiiv1 = (c < 8);
      axiid1 = (c < 8) ? a5[c] : 1'b0;
      reverse1 = 1'b1;
    end

    // 2-bit drop counter saturates at 3
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      axiiv1 = 1'b1; axiid1 = 1'b1;
      @(negedge clk);
      axiiv1 = 1'b0; axiid1 = 1'b0;
      @(negedge clk);
      check($sformatf("sat_frag_%0d", i), 32'(frag_drop1), 32'd1);
      check($sformatf("sat_dcnt_%0d", i), 32'(drop_count1), 32'((i < 3) ? i + 1 : 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lane_bitorder.md
LANE_BITORDER -- requirements
Module: lane_bitorder

Interface
REQ-001 SHALL have parameter LANE_W, default 2: bits per input/output beat; legal values 1, 2, 4.
REQ-002 SHALL have parameter WORD_W, default 8: bits per reordered word; must be a multiple of LANE_W and at least 2*LANE_W.
REQ-003 SHALL have parameter CNT_W, default 16: width of drop_count.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port axiiv, input, 1 bit: input beat valid; no backpressure.
REQ-007 SHALL have port axiid, input, LANE_W bits: input lane, lanes arriving least-significant-lane first.
REQ-008 SHALL have port reverse, input, 1 bit: 1 = emit lanes most-significant first; 0 = emit in arrival order.
REQ-009 SHALL have port axiov, output, 1 bit: output beat valid.
REQ-010 SHALL have port axiod, output, LANE_W bits: output lane.
REQ-011 SHALL have port frag_drop, output, 1 bit: one-cycle pulse when a partial word is discarded.
REQ-012 SHALL have port drop_count, output, CNT_W bits: saturating count of discarded partial words.

Function
REQ-013 SHALL define N = WORD_W/LANE_W beats per word; beat k of a word fills word bits [k*LANE_W +: LANE_W].
REQ-014 SHALL use two word buffers, A and B, in ping-pong: one fills while the other drains.
REQ-015 SHALL have states EMPTY_A, EMPTY_B, SEND_A and SEND_B; out of reset the state is EMPTY_B and buffer A fills first.
REQ-016 SHALL move to SEND_x on the cycle after the Nth consecutive valid beat of buffer x is written.
REQ-017 SHALL, in SEND_x, drive axiov=1 for exactly N consecutive cycles and emit one lane per cycle from buffer x.
REQ-018 SHALL, with reverse latched =1, emit lane order N-1 down to 0, with bits within each lane unchanged.
REQ-019 SHALL, with reverse latched =0, emit lane order 0 up to N-1.
REQ-020 SHALL latch reverse once per word, on the cycle that word's Nth beat is written; a change mid-word or mid-send has no effect until the next word.
REQ-021 SHALL have latency N cycles: a word whose beat 0 is written at cycle t emits its first output beat at cycle t+N.
REQ-022 SHALL, with continuous input, produce continuous output: a word completing during SEND_x goes directly to SEND_other with no axiov gap.
REQ-023 SHALL never interrupt a drain; input gaps never stall or truncate a word already in SEND_x.
REQ-024 SHALL, when axiiv=0 while the fill count is between 1 and N-1, discard the partial word and clear the fill count to 0.
REQ-025 SHALL pulse frag_drop on the cycle after such a discard, and increment drop_count at the same edge as the pulse, saturating at all-ones.
REQ-026 SHALL treat axiiv=0 with fill count 0 as idle: no drop, no pulse.
REQ-027 SHALL, after a gap, restart filling at beat 0 of the buffer not currently draining.
REQ-028 SHALL drive axiod to all-zero whenever axiov=0.
REQ-029 SHALL clear an idle buffer to zero when it enters an EMPTY state with axiiv=0.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, set state EMPTY_B, both fill/drain counters 0, buffers A and B 0, latched reverse 1, axiov 0, axiod 0, frag_drop 0 and drop_count 0.
REQ-031 SHALL, on reset mid-fill or mid-drain, abandon the word at once with no further axiov and no frag_drop for it.
REQ-032 SHALL restart filling at beat 0 on the first valid beat after rst deasserts.

Verification
REQ-033 SHALL cover LANE_W=2, WORD_W=8, reverse=1, beats 01,10,11,00 at cycles 0-3 (word 0x39) -> axiov high at cycles 4-7, axiod 00,11,10,01.
REQ-034 SHALL cover the same stimulus with reverse=0 -> axiod 01,10,11,00 at cycles 4-7.
REQ-035 SHALL cover 8 back-to-back beats forming 0x39 then 0xC6, reverse=1 -> axiov high at cycles 4-11 with no gap; axiod 00,11,10,01,11,00,01,10.
REQ-036 SHALL cover 3 beats then axiiv=0 at cycle 3 -> axiov never asserts; frag_drop high only at cycle 4; drop_count=1; a following full word still emits correctly.
REQ-037 SHALL cover rst=1 at the second output beat of a word -> axiov=0 from the next cycle, all outputs 0, drop_count=0.
REQ-038 SHALL cover LANE_W=1, WORD_W=8, reverse=1, input byte 0xA5 sent LSb first -> output bits 1,0,1,0,0,1,0,1 at cycles 8-15; drop_count saturation is forced with CNT_W=2 -> holds at 3.
